// File: rtl/rshift_deser.sv
// Serial-in, parallel-out deserializer: collects qualified serial bits into WIDTH-bit words
// and hands each completed word to a valid/ready consumer, flagging dropped words.
module rshift_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         sin,
  input  logic                         sin_valid,
  input  logic                         sin_start,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         overflow,
  input  logic                         clr_ovf
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             complete;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      sr_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Datapath: shift, count and output handoff.
  always_comb begin
    cnt_inc  = (sin_start ? '0 : cnt_q) + CntW'(1);
    complete = sin_valid && (cnt_inc == CntW'(WIDTH));
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    if (sin_valid) begin
      // A frame start discards old bits by shifting into an empty register.
      if (MSB_FIRST) begin
        sr_d = sin_start ? {{(WIDTH-1){1'b0}}, sin} : {sr_q[WIDTH-2:0], sin};
      end else begin
        sr_d = sin_start ? {sin, {(WIDTH-1){1'b0}}} : {sin, sr_q[WIDTH-1:1]};
      end
      cnt_d = complete ? '0 : cnt_inc;
    end

    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = clr_ovf ? 1'b0 : ovf_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || out_ready) begin
        data_d  = sr_d;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sin_valid && !complete) state_d = StShift;
      StShift: if (complete) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_data  = data_q;
    out_valid = valid_q;
    overflow  = ovf_q;
    bit_cnt   = cnt_q;
    busy      = (state_q == StShift);
  end

endmodule

// File: tb/tb_rshift_deser.sv
// Directed self-checking bench for rshift_deser; a second instance covers MSB-first order
// and shares the same stimulus.
module tb_rshift_deser;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_start = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] out_data, m_out_data;
  logic       out_valid, m_out_valid;
  logic       busy, m_busy;
  logic [3:0] bit_cnt, m_bit_cnt;
  logic       overflow, m_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rshift_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rstn(rstn), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .bit_cnt(bit_cnt), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  rshift_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rstn(rstn), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(out_ready), .busy(m_busy),
    .bit_cnt(m_bit_cnt), .overflow(m_overflow), .clr_ovf(clr_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends w[0] first, with sin_start on the first bit, no gaps.
  task automatic drive_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      sin       = w[i];
      sin_valid = 1'b1;
      sin_start = (i == 0);
      step();
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bit_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sin = w[i]; sin_valid = 1'b1; sin_start = (i == 0);
      step();
      if (i < 7) begin
        checks++; if (bit_cnt !== 4'(i + 1)) begin errors++; $display("FAIL basic_cnt[%0d]: got %0d want %0d", i, bit_cnt, i + 1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d]: got %b want 1", i, busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, out_valid); end
      end
    end
    sin_valid = 1'b0; sin_start = 1'b0;
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL basic_cnt_end: got %0d want 0", bit_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", out_data); end
    checks++; if (m_out_data !== 8'hA5) begin errors++; $display("FAIL basic_msb_data: got %h want a5", m_out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clear: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL basic_data_hold: got %h want a5", out_data); end
  endtask

  task automatic test_msb_first();
    out_ready = 1'b1;
    drive_word(8'h83);  // bit order 1,1,0,0,0,0,0,1
    checks++; if (m_out_data !== 8'hC1) begin errors++; $display("FAIL msb_data: got %h want c1", m_out_data); end
    checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL msb_valid: got %b want 1", m_out_valid); end
    checks++; if (out_data !== 8'h83) begin errors++; $display("FAIL msb_lsb_data: got %h want 83", out_data); end
    step();
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    w = 8'h3C;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sin = w[i]; sin_valid = 1'b1; sin_start = (i == 0);
      step();
      sin_valid = 1'b0; sin_start = 1'b0; sin = ~sin;
      if (i < 7) begin
        step();
        checks++; if (bit_cnt !== 4'(i + 1)) begin errors++; $display("FAIL gap_cnt[%0d]: got %0d want %0d", i, bit_cnt, i + 1); end
      end
    end
    checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL gap_data: got %h want 3c", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b want 1", out_valid); end
    step();
  endtask

  task automatic test_restart();
    logic [7:0] w;
    int nvalid;
    out_ready = 1'b1;
    w = 8'h81;
    nvalid = 0;
    for (int i = 0; i < 13; i++) begin
      sin = (i < 5) ? 1'b1 : w[i-5];
      sin_valid = 1'b1;
      sin_start = (i == 0) || (i == 5);
      step();
      if (out_valid) nvalid++;
      if (i == 4) begin
        checks++; if (bit_cnt !== 4'd5) begin errors++; $display("FAIL restart_cnt5: got %0d want 5", bit_cnt); end
      end
      if (i == 5) begin
        checks++; if (bit_cnt !== 4'd1) begin errors++; $display("FAIL restart_cnt1: got %0d want 1", bit_cnt); end
      end
    end
    sin_valid = 1'b0; sin_start = 1'b0;
    checks++; if (out_data !== 8'h81) begin errors++; $display("FAIL restart_data: got %h want 81", out_data); end
    step();
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL restart_words: got %0d want 1", nvalid); end

    // Restart landing on the bit that would have completed a word.
    w = 8'h7E;
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      sin = (i < 7) ? 1'b1 : w[i-7];
      sin_valid = 1'b1;
      sin_start = (i == 0) || (i == 7);
      step();
      if (out_valid) nvalid++;
      if (i == 7) begin
        checks++; if (bit_cnt !== 4'd1) begin errors++; $display("FAIL restart_win_cnt: got %0d want 1", bit_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_win_valid: got %b want 0", out_valid); end
      end
    end
    sin_valid = 1'b0; sin_start = 1'b0;
    checks++; if (out_data !== 8'h7E) begin errors++; $display("FAIL restart_win_data: got %h want 7e", out_data); end
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL restart_win_words: got %0d want 1", nvalid); end
    step();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    drive_word(8'h11);
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL ovf_first_data: got %h want 11", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_first_flag: got %b want 0", overflow); end
    drive_word(8'h22);
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL ovf_keep_data: got %h want 11", out_data); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: got %b want 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    out_ready = 1'b0;
    drive_word(8'h33);
    clr_ovf = 1'b1;
    drive_word(8'h44);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    checks++; if (out_data !== 8'h33) begin errors++; $display("FAIL ovf_second_data: got %h want 33", out_data); end
    clr_ovf = 1'b0;
    out_ready = 1'b1;
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    out_ready = 1'b0;
    drive_word(8'h55);
    checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL b2b_first: got %h want 55", out_data); end
    w = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      sin = w[i]; sin_valid = 1'b1; sin_start = (i == 0);
      out_ready = (i == 7);
      step();
      if (i == 6) begin
        checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL b2b_hold: got %h want 55", out_data); end
      end
    end
    sin_valid = 1'b0; sin_start = 1'b0; out_ready = 1'b0;
    checks++; if (out_data !== 8'hAA) begin errors++; $display("FAIL b2b_data: got %h want aa", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b0;
    drive_word(8'h12);  // dropped behind the pending word
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rmw_pre_ovf: got %b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      sin = 1'b1; sin_valid = 1'b1; sin_start = (i == 0);
      step();
    end
    checks++; if (bit_cnt !== 4'd4) begin errors++; $display("FAIL rmw_pre_cnt: got %0d want 4", bit_cnt); end
    sin_valid = 1'b0; sin_start = 1'b0;
    rstn = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmw_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rmw_data: got %h want 00", out_data); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL rmw_cnt: got %0d want 0", bit_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmw_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmw_ovf: got %b want 0", overflow); end
    checks++; if (m_bit_cnt !== 4'd0) begin errors++; $display("FAIL rmw_msb_cnt: got %0d want 0", m_bit_cnt); end
    rstn = 1'b1;
    out_ready = 1'b1;
    drive_word(8'h96);
    checks++; if (out_data !== 8'h96) begin errors++; $display("FAIL rmw_clean_data: got %h want 96", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmw_clean_valid: got %b want 1", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmw_clean_ovf: got %b want 0", overflow); end
    checks++; if (m_out_data !== 8'h69) begin errors++; $display("FAIL rmw_msb_data: got %h want 69", m_out_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_first();
    test_gapped();
    test_restart();
    test_overflow();
    test_back_to_back();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
